// File: rtl/arm_bus_slave.sv
// rtl/arm_bus_slave.sv - ARM chip-select bus slave with strobe sync, DTACK handshake and IRQ register bank
module arm_bus_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 24,
  parameter int NUM_REGS    = 8,
  parameter int ADDR_LSB    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_W-1:0]              bus_addr,
  input  logic [DATA_W-1:0]              bus_din,
  input  logic [DATA_W/8-1:0]            bus_be_n,
  input  logic                           bus_as,
  input  logic                           bus_rs_n,
  input  logic                           bus_ws_n,
  output logic [DATA_W-1:0]              bus_dout,
  output logic                           bus_doe,
  output logic                           bus_dtack_n,
  output logic                           irq,
  input  logic [DATA_W-1:0]              irq_src,
  output logic [(NUM_REGS-2)*DATA_W-1:0] reg_out
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_ACK} state_e;

  logic [SYNC_STAGES-1:0] as_sync_q, rs_sync_q, ws_sync_q;
  logic                   as_s, rs_s, ws_s;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   din_q;
  logic [BE_W-1:0]     be_n_q;
  logic [DATA_W-1:0]   dout_q;
  logic                doe_q;
  logic                dtack_n_q;
  logic                irq_q;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   wmask;
  logic                unused_addr;

  assign unused_addr = ^bus_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      as_sync_q <= '0;
      rs_sync_q <= '1;
      ws_sync_q <= '1;
    end else begin
      as_sync_q <= {as_sync_q[SYNC_STAGES-2:0], bus_as};
      rs_sync_q <= {rs_sync_q[SYNC_STAGES-2:0], bus_rs_n};
      ws_sync_q <= {ws_sync_q[SYNC_STAGES-2:0], bus_ws_n};
    end
  end

  assign as_s = as_sync_q[SYNC_STAGES-1];
  assign rs_s = rs_sync_q[SYNC_STAGES-1];
  assign ws_s = ws_sync_q[SYNC_STAGES-1];

  // Address/data/byte enables are sampled only when leaving IDLE; the bus holds them stable under a strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      din_q     <= '0;
      be_n_q    <= '1;
      dout_q    <= '0;
      doe_q     <= 1'b0;
      dtack_n_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (as_s && !ws_s) begin
            idx_q   <= bus_addr[ADDR_LSB+IDX_W-1:ADDR_LSB];
            din_q   <= bus_din;
            be_n_q  <= bus_be_n;
            state_q <= S_WRITE;
          end else if (as_s && !rs_s) begin
            idx_q   <= bus_addr[ADDR_LSB+IDX_W-1:ADDR_LSB];
            state_q <= S_READ;
          end
        end
        S_WRITE: begin
          dtack_n_q <= 1'b0;
          state_q   <= S_ACK;
        end
        S_READ: begin
          dout_q  <= regs_q[idx_q];
          doe_q   <= 1'b1;
          state_q <= S_ACK;
        end
        S_ACK: begin
          if (as_s && (!rs_s || !ws_s)) begin
            dtack_n_q <= 1'b0;
          end else begin
            dtack_n_q <= 1'b1;
            doe_q     <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wmask = '0;
    for (int b = 0; b < BE_W; b++) begin
      wmask[b*8 +: 8] = {8{~be_n_q[b]}};
    end
  end

  // R0 is write-1-to-clear; the event OR is applied last so a same-cycle set beats the clear.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    if (state_q == S_WRITE) begin
      if (idx_q == '0) begin
        regs_d[0] = regs_q[0] & ~(din_q & wmask);
      end else begin
        regs_d[idx_q] = (regs_q[idx_q] & ~wmask) | (din_q & wmask);
      end
    end
    regs_d[0] = regs_d[0] | irq_src;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      irq_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      irq_q <= |(regs_q[0] & regs_q[1]);
    end
  end

  for (genvar r = 2; r < NUM_REGS; r++) begin : g_reg_out
    assign reg_out[(r-2)*DATA_W +: DATA_W] = regs_q[r];
  end

  assign bus_dout    = dout_q;
  assign bus_doe     = doe_q;
  assign bus_dtack_n = dtack_n_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_arm_bus_slave.sv
// tb/tb_arm_bus_slave.sv - directed-vector bench for arm_bus_slave
module tb_arm_bus_slave;

  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [23:0]  bus_addr = '0;
  logic [31:0]  bus_din = '0;
  logic [3:0]   bus_be_n = 4'hF;
  logic         bus_as = 1'b0;
  logic         bus_rs_n = 1'b1;
  logic         bus_ws_n = 1'b1;
  logic [31:0]  bus_dout;
  logic         bus_doe;
  logic         bus_dtack_n;
  logic         irq;
  logic [31:0]  irq_src = '0;
  logic [191:0] reg_out;

  int n_checks = 0;
  int n_pass   = 0;

  arm_bus_slave #(
    .DATA_W(32), .ADDR_W(24), .NUM_REGS(8), .ADDR_LSB(2), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_din(bus_din),
    .bus_be_n(bus_be_n), .bus_as(bus_as), .bus_rs_n(bus_rs_n), .bus_ws_n(bus_ws_n),
    .bus_dout(bus_dout), .bus_doe(bus_doe), .bus_dtack_n(bus_dtack_n),
    .irq(irq), .irq_src(irq_src), .reg_out(reg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_start(input string tag, input logic [23:0] a, input logic [31:0] d,
                          input logic [3:0] be, input bit with_rs);
    int k;
    bit seen_doe;
    bus_addr = a; bus_din = d; bus_be_n = be;
    bus_as = 1'b1; bus_ws_n = 1'b0;
    if (with_rs) bus_rs_n = 1'b0;
    k = 0; seen_doe = 0;
    do begin
      step();
      k++;
      if (bus_doe) seen_doe = 1;
    end while (bus_dtack_n && k < 20);
    check({tag, "_dtack_lat"}, k, S + 2);
    check({tag, "_no_doe"}, seen_doe, 0);
  endtask

  task automatic release_bus(input string tag);
    int k;
    bus_as = 1'b0; bus_rs_n = 1'b1; bus_ws_n = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (!bus_dtack_n && k < 20);
    check({tag, "_rel_lat"}, k, S + 1);
    check({tag, "_rel_doe"}, bus_doe, 0);
  endtask

  task automatic wr(input string tag, input logic [23:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_start(tag, a, d, be, 0);
    release_bus(tag);
  endtask

  task automatic rd(input string tag, input logic [23:0] a, input logic [31:0] exp);
    int k, doe_k;
    logic [31:0] cap;
    bus_addr = a; bus_as = 1'b1; bus_rs_n = 1'b0;
    k = 0; doe_k = 0; cap = '0;
    do begin
      step();
      k++;
      if (bus_doe && doe_k == 0) begin
        doe_k = k;
        cap = bus_dout;
      end
    end while (bus_dtack_n && k < 20);
    check({tag, "_doe_lat"}, doe_k, S + 2);
    check({tag, "_dtack_lat"}, k, S + 3);
    check({tag, "_data"}, cap, exp);
    release_bus(tag);
  endtask

  task automatic pulse_src(input int bit_i);
    irq_src = '0;
    irq_src[bit_i] = 1'b1;
    step();
    irq_src = '0;
  endtask

  initial begin
    // Reset held with strobes toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_as = ~bus_as; bus_ws_n = ~bus_ws_n; bus_rs_n = (i % 3) != 0;
    end
    check("rst_dtack", bus_dtack_n, 1);
    check("rst_doe", bus_doe, 0);
    check("rst_irq", irq, 0);
    check("rst_regout", |reg_out, 0);
    check("rst_dout", bus_dout, 0);
    bus_as = 1'b0; bus_rs_n = 1'b1; bus_ws_n = 1'b1;
    step();
    rst = 1'b1;
    repeat (3) step();

    // Byte-enable write to R2
    wr_start("be_wr", 24'h8, 32'hDEADBEEF, 4'b1010, 0);
    check("be_wr_r2", reg_out[31:0], 32'h00AD00EF);
    release_bus("be_wr");
    rd("be_rd", 24'h8, 32'h00AD00EF);

    // Read handshake on R7
    wr("r7_wr", 24'h1C, 32'h12345678, 4'b0000);
    check("r7_regout", reg_out[191:160], 32'h12345678);
    rd("r7_rd", 24'h1C, 32'h12345678);

    // Interrupt path
    wr("mask_wr", 24'h4, 32'h1, 4'b0000);
    pulse_src(0);
    check("irq_1cyc", irq, 0);
    step();
    check("irq_2cyc", irq, 1);
    wr_start("w1c", 24'h0, 32'h1, 4'b0000, 0);
    check("irq_at_commit", irq, 1);
    step();
    check("irq_after_w1c", irq, 0);
    release_bus("w1c");
    pulse_src(3);
    repeat (3) step();
    check("irq_masked", irq, 0);
    rd("st_bit3", 24'h0, 32'h8);
    wr("clr3", 24'h0, 32'h8, 4'b0000);

    // Set beats clear on the commit cycle
    irq_src[0] = 1'b1;
    wr_start("setwin", 24'h0, 32'h1, 4'b0000, 0);
    irq_src[0] = 1'b0;
    release_bus("setwin");
    rd("setwin_st", 24'h0, 32'h1);
    check("setwin_irq", irq, 1);
    wr("clr0", 24'h0, 32'h1, 4'b0000);
    check("clr0_irq", irq, 0);

    // Read and write strobes together: write wins, no drive
    wr_start("both", 24'hC, 32'hA5A5A5A5, 4'b0000, 1);
    release_bus("both");
    check("both_r3", reg_out[63:32], 32'hA5A5A5A5);

    // Address 0x20 aliases R0
    pulse_src(5);
    step();
    rd("alias_rd", 24'h20, 32'h20);
    wr("alias_wr", 24'h20, 32'h20, 4'b0000);
    rd("alias_r0", 24'h0, 32'h0);

    // Reset while in ACK
    wr_start("rst_ack", 24'h10, 32'h55, 4'b0000, 0);
    check("rst_ack_r4", reg_out[95:64], 32'h55);
    #1 rst = 1'b0;
    #1;
    check("rst_ack_dtack", bus_dtack_n, 1);
    check("rst_ack_regout", |reg_out, 0);
    check("rst_ack_dout", bus_dout, 0);
    bus_as = 1'b0; bus_ws_n = 1'b1;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arm_bus_slave.md
# arm_bus_slave

Parametrised ARM chip-select bus slave for the FPGA. It sits between the asynchronous ARM/CPLD strobe interface (address, data, byte enables, AS, RS5_B, WS5_B) and the FPGA fabric. It synchronises the strobes and runs a handshake state machine that drives a real DTACK and a data-bus output enable. It also holds a byte-maskable register bank that includes a maskable interrupt controller driving ARM_IRQ.

## Interface
Parameters:
- `DATA_W`, 32: bus data width; multiple of 8.
- `ADDR_W`, 24: bus address width.
- `NUM_REGS`, 8: register count; power of 2, at least 4.
- `ADDR_LSB`, 2: lowest address bit of the register index. Index = `bus_addr[ADDR_LSB+log2(NUM_REGS)-1 : ADDR_LSB]`; higher address bits are ignored.
- `SYNC_STAGES`, 2: flop stages on each strobe; at least 2.

Ports:
- `clk` in 1: fabric clock (FPGA_CLK1, 100 MHz). The only clock.
- `rst` in 1: asynchronous, active-low reset (SYS_RST_N).
- `bus_addr` in ADDR_W: ARM address.
- `bus_din` in DATA_W: ARM write data (input side of the tristate).
- `bus_be_n` in DATA_W/8: active-low byte enables.
- `bus_as` in 1: address strobe, active-high (CPLD_AS).
- `bus_rs_n` in 1: read strobe, active-low.
- `bus_ws_n` in 1: write strobe, active-low.
- `bus_dout` out DATA_W: read data, registered.
- `bus_doe` out 1: tristate enable for `bus_dout`. The top level drives ARM_D only while this is 1.
- `bus_dtack_n` out 1: active-low transfer acknowledge (ARM_DTACK).
- `irq` out 1: active-high interrupt (ARM_IRQ), registered.
- `irq_src` in DATA_W: per-bit event inputs, synchronous to `clk`.
- `reg_out` out (NUM_REGS-2)*DATA_W: registers 2..NUM_REGS-1, flattened. Register 2 occupies the LSBs.

## Operation
Strobe synchronisation:
- `bus_as`, `bus_rs_n` and `bus_ws_n` each pass through SYNC_STAGES flops. The synced values are `as_s`, `rs_s`, `ws_s`.
- Address, data and byte enables are not synchronised. They are sampled on the IDLE exit cycle; the bus guarantees they are stable while a strobe is asserted.

Register map:
- R0 IRQ_STATUS: sticky.
  - Bit i sets on any cycle in which `irq_src[i]`=1.
  - A write clears every bit whose data bit is 1 within an enabled byte (write-1-to-clear).
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- R1 IRQ_MASK: plain read/write.
- R2..R(NUM_REGS-1): plain read/write, exposed on `reg_out`.
- Writes update only the bytes whose `bus_be_n` bit is 0. Reads always return the full word.
- `irq` is registered each cycle as `|(IRQ_STATUS & IRQ_MASK)`.

State machine (IDLE, WRITE, READ, ACK):
- IDLE:
  - `as_s`=1 and `ws_s`=0: capture addr, din and be; go to WRITE. Write has priority if `rs_s` is also 0.
  - Otherwise, `as_s`=1 and `rs_s`=0: capture addr; go to READ.
- WRITE: commit the masked write to the indexed register; go to ACK.
- READ: load `bus_dout` from the indexed register; set `bus_doe`=1; go to ACK.
- ACK:
  - `bus_dtack_n`=0; `bus_doe` is held at its value.
  - Stay in ACK while `as_s`=1 and (`rs_s`=0 or `ws_s`=0).
  - Otherwise go to IDLE and deassert `bus_dtack_n` and `bus_doe`.
- Exactly one register access per strobe assertion. A strobe held low does not retrigger.

Reset values (all outputs and state):
- State IDLE; all registers 0 (including STATUS and MASK); sync flops idle (as=0, rs_n=1, ws_n=1).
- `bus_dout`=0, `bus_doe`=0, `bus_dtack_n`=1, `irq`=0.
- Reset asserted mid-transaction aborts immediately (asynchronously), and no partial write lands after reset.

## Timing
- Strobe edge at cycle 0 is visible in `as_s`/`rs_s`/`ws_s` at cycle SYNC_STAGES.
- The FSM leaves IDLE at SYNC_STAGES+1.
- Write: register value changes at SYNC_STAGES+2; `bus_dtack_n` falls at SYNC_STAGES+2.
- Read: `bus_dout` is valid and `bus_doe`=1 at SYNC_STAGES+2; `bus_dtack_n` falls at SYNC_STAGES+3. Data is therefore stable one cycle before acknowledge.
- Strobe release to `bus_dtack_n`=1 and `bus_doe`=0: SYNC_STAGES+1 cycles.
- `irq_src` pulse to `irq` high (if unmasked): 2 cycles (status set, then irq register).
- A W1C write drops `irq` 1 cycle after the commit.

## Test plan
- Reset: hold `rst`=0 with strobes toggling. Required: `bus_dtack_n`=1, `bus_doe`=0, `irq`=0, `reg_out`=0.
- Byte-enable write: write 0xDEADBEEF to R2 (addr 0x8) with `bus_be_n`=4'b1010, R2 previously 0. Required: R2 reads 0x00AD00EF; `bus_dtack_n` low from SYNC_STAGES+2 until SYNC_STAGES+1 cycles after strobe release.
- Read handshake: after writing 0x12345678 to R7, read R7. Required: `bus_dout`=0x12345678 with `bus_doe`=1 one cycle before `bus_dtack_n` falls; `bus_doe` returns to 0 after release.
- Interrupt: MASK=0x1; pulse `irq_src[0]` for one cycle. Required: `irq`=1 two cycles later. Then write 0x1 to R0. Required: `irq`=0 one cycle after the commit. `irq_src[3]` pulse with MASK=0x1 leaves `irq`=0 but sets STATUS bit 3.
- Corner cases:
  - `irq_src[0]` high on the W1C commit cycle: bit 0 stays set.
  - `rs_n` and `ws_n` both low: the write executes and no read drive occurs.
  - Address 0x20 with NUM_REGS=8: aliases to R0.
  - Reset asserted while in ACK: `bus_dtack_n`=1 immediately.
